// File: rtl/core_pkg.sv
// Shared types for the ID/EX boundary: ALU opcodes, forward selects and the
// packed control word carried from decode into execute.
package core_pkg;

  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic    valid;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    alu_src;
    alu_op_e alu_control;
  } id_ex_ctrl_t;

endpackage

// File: rtl/fwd_unit.sv
// Bypass select generation for the two EX source operands.
// MEM beats WB; register x0 never forwards.
module fwd_unit
  import core_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] ex_rs1,
  input  logic [RA_W-1:0] ex_rs2,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_reg_write,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_reg_write,
  output fwd_sel_e        fwd_a,
  output fwd_sel_e        fwd_b
);

  function automatic fwd_sel_e pick(input logic [RA_W-1:0] rs);
    fwd_sel_e sel;
    sel = FWD_REG;
    if (mem_reg_write && (mem_rd != RA_W'(REG_ZERO)) && (mem_rd == rs))
      sel = FWD_MEM;
    else if (wb_reg_write && (wb_rd != RA_W'(REG_ZERO)) && (wb_rd == rs))
      sel = FWD_WB;
    return sel;
  endfunction

  always_comb begin
    fwd_a = pick(ex_rs1);
    fwd_b = pick(ex_rs2);
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall detection
// and flush/stall bubble insertion. Feeds the combinational ALU directly.
module ex_operand_stage
  import core_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rd1,
  input  logic [XLEN-1:0] id_rd2,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [2:0]      id_alu_control,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_branch,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_reg_write,
  input  logic [XLEN-1:0] mem_result,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_result,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_src_a,
  output logic [XLEN-1:0] ex_src_b,
  output logic [2:0]      ex_alu_control,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch
);

  id_ex_ctrl_t     ctrl_q;
  logic [XLEN-1:0] pc_q, rd1_q, rd2_q, imm_q;
  logic [RA_W-1:0] rs1_q, rs2_q, rd_q;
  logic            bubble;
  fwd_sel_e        fwd_a, fwd_b;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  // Load-use: the load in EX cannot supply its data until it reaches WB-side bypass.
  assign stall_o = id_valid && ctrl_q.valid && ctrl_q.mem_read &&
                   (rd_q != RA_W'(REG_ZERO)) &&
                   ((rd_q == id_rs1) || (rd_q == id_rs2));

  assign bubble = flush_i || stall_o;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; blocking here would leak new values across the bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      pc_q   <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
    end else if (bubble) begin
      // Only the control bits are killed; data fields simply hold.
      ctrl_q.valid     <= 1'b0;
      ctrl_q.reg_write <= 1'b0;
      ctrl_q.mem_read  <= 1'b0;
      ctrl_q.mem_write <= 1'b0;
      ctrl_q.branch    <= 1'b0;
    end else begin
      ctrl_q.valid       <= id_valid;
      ctrl_q.reg_write   <= id_reg_write & id_valid;
      ctrl_q.mem_read    <= id_mem_read  & id_valid;
      ctrl_q.mem_write   <= id_mem_write & id_valid;
      ctrl_q.branch      <= id_branch    & id_valid;
      ctrl_q.alu_src     <= id_alu_src;
      ctrl_q.alu_control <= alu_op_e'(id_alu_control);
      pc_q  <= id_pc;
      rd1_q <= id_rd1;
      rd2_q <= id_rd2;
      imm_q <= id_imm;
      rs1_q <= id_rs1;
      rs2_q <= id_rs2;
      rd_q  <= id_rd;
    end
  end

  fwd_unit #(.RA_W(RA_W)) u_fwd (
    .ex_rs1        (rs1_q),
    .ex_rs2        (rs2_q),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b)
  );

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case statement can infer a latch.
  always_comb begin
    fwd_rs1 = rd1_q;
    fwd_rs2 = rd2_q;
    case (fwd_a)
      FWD_MEM: fwd_rs1 = mem_result;
      FWD_WB:  fwd_rs1 = wb_result;
      default: fwd_rs1 = rd1_q;
    endcase
    case (fwd_b)
      FWD_MEM: fwd_rs2 = mem_result;
      FWD_WB:  fwd_rs2 = wb_result;
      default: fwd_rs2 = rd2_q;
    endcase
  end

  assign ex_src_a       = fwd_rs1;
  assign ex_src_b       = ctrl_q.alu_src ? imm_q : fwd_rs2;
  assign ex_store_data  = fwd_rs2;
  assign ex_alu_control = ctrl_q.alu_control;
  assign ex_pc          = pc_q;
  assign ex_imm         = imm_q;
  assign ex_rd          = rd_q;
  assign ex_valid       = ctrl_q.valid;
  assign ex_reg_write   = ctrl_q.reg_write & ctrl_q.valid;
  assign ex_mem_read    = ctrl_q.mem_read  & ctrl_q.valid;
  assign ex_mem_write   = ctrl_q.mem_write & ctrl_q.valid;
  assign ex_branch      = ctrl_q.branch    & ctrl_q.valid;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: pass-through, forwarding priority,
// x0 handling, load-use stall, flush, and asynchronous reset.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_alu_control;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_branch;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_result, wb_result;
  logic        flush_i;
  logic        stall_o, ex_valid;
  logic [31:0] ex_src_a, ex_src_b, ex_store_data, ex_pc, ex_imm;
  logic [2:0]  ex_alu_control;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ex_operand_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_rd1         (id_rd1),
    .id_rd2         (id_rd2),
    .id_imm         (id_imm),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rd          (id_rd),
    .id_alu_control (id_alu_control),
    .id_alu_src     (id_alu_src),
    .id_reg_write   (id_reg_write),
    .id_mem_read    (id_mem_read),
    .id_mem_write   (id_mem_write),
    .id_branch      (id_branch),
    .mem_rd         (mem_rd),
    .mem_reg_write  (mem_reg_write),
    .mem_result     (mem_result),
    .wb_rd          (wb_rd),
    .wb_reg_write   (wb_reg_write),
    .wb_result      (wb_result),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .ex_valid       (ex_valid),
    .ex_src_a       (ex_src_a),
    .ex_src_b       (ex_src_b),
    .ex_alu_control (ex_alu_control),
    .ex_store_data  (ex_store_data),
    .ex_pc          (ex_pc),
    .ex_imm         (ex_imm),
    .ex_rd          (ex_rd),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_branch      (ex_branch)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] rd1,
                        input logic [31:0] rd2, input logic [31:0] imm,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [2:0] op, input logic asrc, input logic rw,
                        input logic mr, input logic mw, input logic br);
    id_valid = v;  id_pc = pc;  id_rd1 = rd1;  id_rd2 = rd2;  id_imm = imm;
    id_rs1 = rs1;  id_rs2 = rs2;  id_rd = rd;  id_alu_control = op;
    id_alu_src = asrc;  id_reg_write = rw;  id_mem_read = mr;
    id_mem_write = mw;  id_branch = br;
  endtask

  task automatic clear_bypass();
    mem_rd = '0;  mem_reg_write = 1'b0;  mem_result = '0;
    wb_rd  = '0;  wb_reg_write  = 1'b0;  wb_result  = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;  flush_i = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    clear_bypass();
    #12;
    check("rst_valid",  ex_valid, 0);
    check("rst_aluop",  ex_alu_control, 0);
    check("rst_stall",  stall_o, 0);
    check("rst_src_a",  ex_src_a, 0);
    rst_n = 1'b1;

    // Plain pass-through
    set_id(1, 32'h100, 5, 32'h22, 7, 1, 2, 6, 3'b000, 1, 1, 0, 0, 0);
    tick();
    check("pt_src_a",  ex_src_a, 5);
    check("pt_src_b",  ex_src_b, 7);
    check("pt_valid",  ex_valid, 1);
    check("pt_pc",     ex_pc, 32'h100);
    check("pt_rd",     ex_rd, 6);
    check("pt_rw",     ex_reg_write, 1);
    check("pt_store",  ex_store_data, 32'h22);
    check("pt_stall",  stall_o, 0);

    // MEM-over-WB priority on rs1, WB forward on rs2
    set_id(1, 32'h104, 32'h11, 32'h22, 0, 3, 2, 9, 3'b001, 0, 1, 0, 0, 0);
    tick();
    check("fw_none_a", ex_src_a, 32'h11);
    check("fw_op",     ex_alu_control, 3'b001);
    mem_rd = 3; mem_reg_write = 1; mem_result = 32'hAA;
    wb_rd  = 3; wb_reg_write  = 1; wb_result  = 32'hBB;
    #1 check("fw_mem_a", ex_src_a, 32'hAA);
    mem_reg_write = 0;
    #1 check("fw_wb_a",  ex_src_a, 32'hBB);
    wb_rd = 2;
    #1 check("fw_wb_b",     ex_src_b, 32'hBB);
    check("fw_wb_store", ex_store_data, 32'hBB);
    check("fw_reg_a",    ex_src_a, 32'h11);
    clear_bypass();

    // x0 never forwards
    set_id(1, 32'h108, 32'h33, 0, 0, 0, 0, 1, 3'b010, 0, 1, 0, 0, 0);
    tick();
    mem_rd = 0; mem_reg_write = 1; mem_result = 32'hFF;
    wb_rd  = 0; wb_reg_write  = 1; wb_result  = 32'hEE;
    #1 check("x0_src_b",  ex_src_b, 0);
    check("x0_store",  ex_store_data, 0);
    check("x0_src_a",  ex_src_a, 32'h33);
    clear_bypass();

    // Load-use stall: load rd=4 in EX, consumer reads rs2=4
    set_id(1, 32'h10C, 0, 0, 32'h10, 1, 0, 4, 3'b000, 1, 1, 1, 0, 0);
    tick();
    check("lu_memrd",  ex_mem_read, 1);
    set_id(1, 32'h110, 32'h55, 32'h66, 0, 5, 4, 7, 3'b011, 0, 1, 0, 0, 0);
    #1 check("lu_stall", stall_o, 1);
    id_valid = 0;
    #1 check("lu_noid",  stall_o, 0);
    id_valid = 1;
    tick();
    check("lu_bub_v",  ex_valid, 0);
    check("lu_bub_rw", ex_reg_write, 0);
    check("lu_bub_mr", ex_mem_read, 0);
    check("lu_hold_rd", ex_rd, 4);
    check("lu_drop",   stall_o, 0);
    mem_rd = 4; mem_reg_write = 1; mem_result = 32'h99;
    tick();
    check("lu_cons_v",  ex_valid, 1);
    check("lu_cons_rd", ex_rd, 7);
    check("lu_fwd",     ex_store_data, 32'h99);
    check("lu_src_a",   ex_src_a, 32'h55);
    clear_bypass();

    // Load to x0 never stalls
    set_id(1, 32'h114, 0, 0, 0, 1, 0, 0, 3'b000, 1, 1, 1, 0, 0);
    tick();
    set_id(1, 32'h118, 0, 0, 0, 0, 0, 3, 3'b000, 0, 1, 0, 0, 0);
    #1 check("x0_nostall", stall_o, 0);

    // Flush together with stall: one bubble, then normal load
    set_id(1, 32'h11C, 0, 0, 0, 1, 0, 8, 3'b000, 1, 1, 1, 0, 0);
    tick();
    set_id(1, 32'h200, 32'h77, 0, 0, 8, 0, 9, 3'b100, 0, 1, 0, 0, 0);
    flush_i = 1;
    #1 check("fs_stall", stall_o, 1);
    tick();
    flush_i = 0;
    check("fs_bub_v",  ex_valid, 0);
    check("fs_bub_mr", ex_mem_read, 0);
    check("fs_hold",   ex_rd, 8);
    tick();
    check("fs_next_v",  ex_valid, 1);
    check("fs_next_rd", ex_rd, 9);
    check("fs_next_pc", ex_pc, 32'h200);

    // Flush alone kills a branch
    set_id(1, 32'h204, 0, 0, 0, 0, 0, 10, 3'b000, 0, 1, 0, 0, 1);
    flush_i = 1;
    tick();
    flush_i = 0;
    check("fl_valid",  ex_valid, 0);
    check("fl_branch", ex_branch, 0);

    // Async reset mid-stream
    set_id(1, 32'h300, 0, 0, 32'h44, 0, 0, 12, 3'b100, 0, 1, 0, 1, 1);
    tick();
    check("ar_pre_v",  ex_valid, 1);
    check("ar_pre_br", ex_branch, 1);
    check("ar_pre_mw", ex_mem_write, 1);
    check("ar_pre_op", ex_alu_control, 3'b100);
    #2 rst_n = 0;
    #1;
    check("ar_valid", ex_valid, 0);
    check("ar_br",    ex_branch, 0);
    check("ar_mw",    ex_mem_write, 0);
    check("ar_rw",    ex_reg_write, 0);
    check("ar_op",    ex_alu_control, 0);
    check("ar_pc",    ex_pc, 0);
    check("ar_stall", stall_o, 0);
    rst_n = 1;
    tick();
    check("ar_rel_v",  ex_valid, 1);
    check("ar_rel_rd", ex_rd, 12);
    check("ar_rel_imm", ex_imm, 32'h44);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

Registered ID/EX boundary of the pipelined RISC-V core. It captures decoded operands and control from the decode stage and resolves data hazards. It drives the ALU's `SrcA`, `SrcB` and `ALUControl` directly. Forwarding from the MEM and WB stages, load-use stall generation and branch-flush bubble insertion are handled here, so the ALU stays purely combinational.

## Interface
- `XLEN`, 32: datapath width.
- `RA_W`, 5: register-address width.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  decode holds a real instruction.
- `id_pc`, `id_rd1`, `id_rd2`, `id_imm`  in  XLEN each  PC, register-file reads, sign-extended immediate.
- `id_rs1`, `id_rs2`, `id_rd`  in  RA_W each  source and destination register numbers.
- `id_alu_control`  in  3  ALU opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT.
- `id_alu_src`  in  1  1 selects `id_imm` as SrcB.
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_branch`  in  1 each  decoded control.
- `mem_rd`  in  RA_W  MEM-stage destination; `mem_reg_write`  in  1; `mem_result`  in  XLEN.
- `wb_rd`  in  RA_W  WB-stage destination; `wb_reg_write`  in  1; `wb_result`  in  XLEN.
- `flush_i`  in  1  branch mispredict; kills the instruction entering EX.
- `stall_o`  out  1  load-use stall request to fetch and decode (combinational).
- `ex_valid`  out  1  EX holds a real instruction.
- `ex_src_a`, `ex_src_b`  out  XLEN  forwarded ALU operands (combinational from register plus bypass).
- `ex_alu_control`  out  3  registered opcode.
- `ex_store_data`  out  XLEN  forwarded rs2 value, for stores.
- `ex_pc`, `ex_imm`  out  XLEN  registered.
- `ex_rd`  out  RA_W  registered destination.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_branch`  out  1  registered, gated by valid.

## Operation
- **Pipeline register:** one bank holding every `id_*` field. It loads every cycle unless a bubble is inserted.
- **Bubble:** `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write` and `ex_branch` are cleared. Data fields are don't-care but are held at their previous values.
- **Load-use hazard:**
  - `stall_o = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2))`.
  - While `stall_o` is high, a bubble is loaded. Decode is responsible for holding its own outputs.
- **Flush:** `flush_i` loads a bubble.
- **Priority:** `flush_i` > `stall_o` > normal load. `stall_o` is still driven while `flush_i` is high; upstream ignores it.
- **Forwarding** for rs1 and rs2 independently, using the registered `ex_rs1` / `ex_rs2`:
  - Use `mem_result` if `mem_reg_write & mem_rd != 0 & mem_rd == ex_rsN`.
  - Otherwise use `wb_result` if `wb_reg_write & wb_rd != 0 & wb_rd == ex_rsN`.
  - Otherwise use the registered `rdN`.
  - MEM always beats WB. Register x0 never forwards.
- **Operand outputs:** `ex_src_a` is forwarded rs1. `ex_src_b` is `ex_imm` if the registered `alu_src` is set, else forwarded rs2. `ex_store_data` is always forwarded rs2.
- **Reset:** asynchronous and immediate. All registered outputs go to 0, including `ex_alu_control` = 000 (ADD) and `ex_valid` = 0. `stall_o` is therefore 0 during reset.

## Timing
- Latency is one cycle: the `id_*` fields sampled at edge N appear on the `ex_*` outputs after edge N.
- Forward muxes are combinational within the EX cycle. The critical path is `mem_result` → mux → ALU.
- A stall costs exactly one bubble per load-use pair. In the next cycle the load is in MEM, `ex_mem_read` of the bubble is 0, so `stall_o` drops and the consumer enters EX with a WB/MEM forward available.
- Flush and stall in the same cycle: a single bubble is loaded.
- Reset released mid-stream: the first edge after release loads `id_*` normally.

## Structure
- Package `core_pkg` holds:
  - `alu_op_e`, a 3-bit enum matching the ALU encoding.
  - `fwd_sel_e`: REG, MEM, WB.
  - `id_ex_ctrl_t`, a packed struct of valid, reg_write, mem_read, mem_write, branch, alu_src and alu_control.
  - Constant `REG_ZERO = 0`.
- One sub-module, `fwd_unit`: pure combinational. It takes `ex_rs1`, `ex_rs2` and the MEM/WB rd/reg_write signals and returns two `fwd_sel_e` selects. It is instantiated once.

## Test plan
- **Plain pass-through:** `id_rd1=5`, `id_imm=7`, `alu_src=1`, opcode 000, no hazards → next cycle `ex_src_a=5`, `ex_src_b=7`, `ex_valid=1`.
- **MEM-over-WB priority:** `ex_rs1=3`, `mem_rd=3` with `mem_result=0xAA`, `wb_rd=3` with `wb_result=0xBB` → `ex_src_a=0xAA`. Drop `mem_reg_write` → `0xBB`.
- **x0 never forwards:** `ex_rs2=0`, `mem_rd=0`, `mem_reg_write=1`, `mem_result=0xFF`, `alu_src=0` → `ex_src_b` equals the registered rd2 (0).
- **Load-use:** EX holds a load with `rd=4`; ID has `rs2=4` → `stall_o=1` that cycle. The next cycle has `ex_valid=0` and `ex_reg_write=0`, and `stall_o=0`.
- **Flush plus stall together:** `flush_i=1` while `stall_o=1` → one bubble. The following cycle loads `id_*` normally.
- **Async reset mid-stream:** assert `rst_n=0` between edges → `ex_valid` and all control outputs go to 0 immediately, before the next `clk` edge.
